// File: rtl/upc_pkg.sv
// Shared definitions for the microprogram sequencer: op encodings and default address width.
package upc_pkg;

  localparam int UPC_ADDR_W = 11;

  typedef enum logic [1:0] {
    UPC_NEXT = 2'b00,
    UPC_JUMP = 2'b01,
    UPC_CALL = 2'b10,
    UPC_RET  = 2'b11
  } upc_op_e;

endpackage

// File: rtl/upc_stack.sv
// LIFO return-address stack. A push when full and a pop when empty are both ignored.
module upc_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [2**IDX_W];
  logic [SP_W-1:0]  top_idx;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp - 1'b1;
  assign dout    = mem[top_idx[IDX_W-1:0]];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // NOTE: the storage array has no reset; entries are only read below sp,
  // so stale contents are unobservable and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/upc_sequencer.sv
// Microprogram counter: sequential step, conditional jump, call/return via a
// small return-address stack, and a sticky overflow/underflow error flag.
module upc_sequencer
  import upc_pkg::*;
#(
  parameter int ADDR_W      = UPC_ADDR_W,
  parameter int STEP        = 2,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        op,
  input  logic              cond,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] upc,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              err
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_ADDR);

  upc_op_e          op_e;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] upc_nxt;
  logic [ADDR_W-1:0] ret_addr;
  logic [SP_W-1:0]   sp;
  logic              st_full;
  logic              st_empty;
  logic              do_push;
  logic              do_pop;
  logic              err_set;

  assign op_e = upc_op_e'(op);

  // Carry out of the adder is dropped so the address wraps modulo 2^ADDR_W.
  assign seq = upc + STEP_V;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    upc_nxt = seq;
    do_push = 1'b0;
    do_pop  = 1'b0;
    err_set = 1'b0;
    unique case (op_e)
      UPC_NEXT: ;
      UPC_JUMP: if (cond) upc_nxt = target;
      UPC_CALL: begin
        if (cond) begin
          if (st_full) begin
            err_set = 1'b1;
          end else begin
            do_push = 1'b1;
            upc_nxt = target;
          end
        end
      end
      UPC_RET: begin
        if (st_empty) begin
          err_set = 1'b1;
        end else begin
          do_pop  = 1'b1;
          upc_nxt = ret_addr;
        end
      end
      default: ;
    endcase
  end

  upc_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (en && do_push),
    .pop   (en && do_pop),
    .din   (seq),
    .dout  (ret_addr),
    .sp    (sp),
    .full  (st_full),
    .empty (st_empty)
  );

  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      upc <= RESET_V;
      err <= 1'b0;
    end else if (en) begin
      upc <= upc_nxt;
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_upc_sequencer.sv
// Self-checking bench for upc_sequencer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_upc_sequencer;

  localparam int ADDR_W     = 11;
  localparam int STEP       = 2;
  localparam int DEPTH      = 4;
  localparam int RESET_ADDR = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [1:0]        op;
  logic              cond;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] upc;
  logic              stack_empty;
  logic              stack_full;
  logic              err;

  int checks = 0;
  int errors = 0;

  int m_upc;
  int m_stack[$];
  bit m_err;

  upc_sequencer #(
    .ADDR_W      (ADDR_W),
    .STEP        (STEP),
    .STACK_DEPTH (DEPTH),
    .RESET_ADDR  (RESET_ADDR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .op          (op),
    .cond        (cond),
    .target      (target),
    .upc         (upc),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the stack is a queue, addresses are plain integers.
  task automatic model_step();
    int seq;
    seq = (m_upc + STEP) % (2 ** ADDR_W);
    if (rst) begin
      m_upc = RESET_ADDR;
      m_stack.delete();
      m_err = 1'b0;
    end else if (en) begin
      case (op)
        2'b00: m_upc = seq;
        2'b01: m_upc = cond ? int'(target) : seq;
        2'b10: begin
          if (!cond) begin
            m_upc = seq;
          end else if (m_stack.size() == DEPTH) begin
            m_upc = seq;
            m_err = 1'b1;
          end else begin
            m_stack.push_back(seq);
            m_upc = int'(target);
          end
        end
        default: begin
          if (m_stack.size() == 0) begin
            m_upc = seq;
            m_err = 1'b1;
          end else begin
            m_upc = m_stack.pop_back();
          end
        end
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [1:0] o,
                       input logic c, input int t, input string tag);
    rst    = r;
    en     = e;
    op     = o;
    cond   = c;
    target = t[ADDR_W-1:0];
    @(posedge clk);
    #1;
    model_step();
    check({tag, " upc"},   32'(upc),         32'(m_upc));
    check({tag, " empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    check({tag, " full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
    check({tag, " err"},   32'(err),         32'(m_err));
  endtask

  initial begin
    m_upc = 0;
    m_err = 1'b0;

    // 1. reset for two cycles, then three sequential steps
    cycle(1, 1, 2'b00, 0, 0, "rst0");
    cycle(1, 1, 2'b01, 1, 'h123, "rst1");
    check("reset upc", 32'(upc), 32'(RESET_ADDR));
    check("reset empty", 32'(stack_empty), 32'd1);
    check("reset err", 32'(err), 32'd0);
    cycle(0, 1, 2'b00, 0, 0, "next1");
    check("next1 abs", 32'(upc), 32'h2);
    cycle(0, 1, 2'b00, 0, 0, "next2");
    cycle(0, 1, 2'b00, 0, 0, "next3");
    check("next3 abs", 32'(upc), 32'h6);

    // 2. wrap around the top of the address space
    cycle(0, 1, 2'b01, 1, 'h7FE, "jmp7fe");
    check("jmp7fe abs", 32'(upc), 32'h7FE);
    cycle(0, 1, 2'b00, 0, 0, "wrap0");
    check("wrap0 abs", 32'(upc), 32'h000);
    cycle(0, 1, 2'b01, 1, 'h7FF, "jmp7ff");
    cycle(0, 1, 2'b00, 0, 0, "wrap1");
    check("wrap1 abs", 32'(upc), 32'h001);
    cycle(0, 1, 2'b01, 0, 'h555, "jmp_nc");

    // 3. single call / return
    cycle(0, 1, 2'b01, 1, 'h010, "to010");
    cycle(0, 1, 2'b10, 1, 'h100, "call100");
    check("call100 abs", 32'(upc), 32'h100);
    cycle(0, 1, 2'b00, 0, 0, "in_sub");
    check("in_sub abs", 32'(upc), 32'h102);
    cycle(0, 1, 2'b11, 0, 0, "ret1");
    check("ret1 abs", 32'(upc), 32'h012);
    check("ret1 empty", 32'(stack_empty), 32'd1);
    cycle(0, 1, 2'b10, 0, 'h333, "call_nc");

    // 4. nesting to full, overflow, then unwind
    cycle(0, 1, 2'b01, 1, 'h000, "to000");
    cycle(0, 1, 2'b10, 1, 'h200, "callA");
    cycle(0, 1, 2'b10, 1, 'h300, "callB");
    cycle(0, 1, 2'b10, 1, 'h400, "callC");
    cycle(0, 1, 2'b10, 1, 'h500, "callD");
    check("nest full", 32'(stack_full), 32'd1);
    cycle(0, 1, 2'b10, 1, 'h600, "callE");
    check("ovf upc", 32'(upc), 32'h502);
    check("ovf err", 32'(err), 32'd1);
    cycle(0, 1, 2'b11, 0, 0, "retD");
    check("retD abs", 32'(upc), 32'h402);
    cycle(0, 1, 2'b11, 0, 0, "retC");
    check("retC abs", 32'(upc), 32'h302);
    cycle(0, 1, 2'b11, 0, 0, "retB");
    check("retB abs", 32'(upc), 32'h202);
    cycle(0, 1, 2'b11, 0, 0, "retA");
    check("retA abs", 32'(upc), 32'h002);

    // 5. underflow from a clean state, then en=0 hold
    cycle(1, 0, 2'b00, 0, 0, "rst5");
    cycle(0, 1, 2'b01, 1, 'h020, "to020");
    cycle(0, 1, 2'b11, 0, 0, "unf");
    check("unf upc", 32'(upc), 32'h022);
    check("unf err", 32'(err), 32'd1);
    cycle(0, 0, 2'b01, 1, 'h3AA, "hold");
    check("hold abs", 32'(upc), 32'h022);

    // 6. reset inside nested calls discards the stack
    cycle(1, 0, 2'b00, 0, 0, "rst6");
    cycle(0, 1, 2'b10, 1, 'h140, "c6a");
    cycle(0, 1, 2'b10, 1, 'h240, "c6b");
    cycle(1, 1, 2'b11, 0, 0, "rst_mid");
    check("rst_mid upc", 32'(upc), 32'(RESET_ADDR));
    check("rst_mid empty", 32'(stack_empty), 32'd1);
    check("rst_mid err", 32'(err), 32'd0);
    cycle(0, 1, 2'b11, 0, 0, "ret_after");
    check("ret_after err", 32'(err), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2047)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
